a2d_spi_serf: RTL and testbench

- Cycle-accurate, synthesizable responder for the A2D converter side of the sensor SPI link.
- Receives 16-bit channel commands from the SPI monarch on MOSI.
- Returns the selected channel's 12-bit conversion result on MISO during the following frame.
- Serves as the converter stand-in in the Segway testbench and as an FPGA loopback target for the A2D interface.

---
 rtl/a2d_spi_serf_if.sv | 17 +
 rtl/a2d_spi_serf.sv | 215 +++++++++++++++++++++
 tb/tb_a2d_spi_serf.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/a2d_spi_serf_if.sv
// ----------------------------------------------------------------------------
// a2d_spi_serf_if
// SPI pin bundle between the A2D interface (monarch) and the converter side.
//   SS_n : serf select, active low, idle high      (monarch -> serf)
//   SCLK : serial clock, idle high                 (monarch -> serf)
//   MOSI : command bit, changes on SCLK fall       (monarch -> serf)
//   MISO : response bit, changes on SCLK fall      (serf -> monarch)
// ----------------------------------------------------------------------------
interface a2d_spi_serf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_serf.sv
// ----------------------------------------------------------------------------
// a2d_spi_serf
// Converter-side SPI responder. Latches a 16-bit channel command per frame and
// returns that channel's 12-bit result during the following frame.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   spi (slave)     SS_n / SCLK / MOSI in, MISO out (registered)
//   lft_ld_val      12-bit value for channel 0
//   rght_ld_val     12-bit value for channel 4
//   steer_val       12-bit value for channel 5
//   batt_val        12-bit value for channel 6
//   cmd_vld         one-clk pulse after a well-formed command is latched
//   last_chnl       channel of the most recent well-formed command
//   err             sticky malformed-frame flag, cleared only by rst
//
// Build option: define A2D_SERF_CHNL_TAG_EN to tag the response upper nibble
// with {1'b1, chnl} (well-formed) or 4'hF (malformed); otherwise it is 4'h0.
// ----------------------------------------------------------------------------
module a2d_spi_serf #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [11:0] BAD_CMD_DATA = 12'hFFF
) (
    input  logic              clk,
    input  logic              rst,
    a2d_spi_serf_if.slave     spi,
    input  logic [11:0]       lft_ld_val,
    input  logic [11:0]       rght_ld_val,
    input  logic [11:0]       steer_val,
    input  logic [11:0]       batt_val,
    output logic              cmd_vld,
    output logic [2:0]        last_chnl,
    output logic              err
);

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        DONE      = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    // Synchronizers, preset high so reset release never shows an edge.
    logic [SYNC_STAGES-1:0] ss_ff, sclk_ff, mosi_ff;
    logic                   ss_prev, sclk_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_ff     <= '1;
            sclk_ff   <= '1;
            mosi_ff   <= '1;
            ss_prev   <= 1'b1;
            sclk_prev <= 1'b1;
        end else begin
            ss_ff     <= {ss_ff[SYNC_STAGES-2:0], spi.SS_n};
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], spi.SCLK};
            mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], spi.MOSI};
            ss_prev   <= ss_ff[SYNC_STAGES-1];
            sclk_prev <= sclk_ff[SYNC_STAGES-1];
        end
    end

    logic ss_sync, mosi_sync;
    logic ss_fall, ss_rise, sclk_fall, sclk_rise;

    assign ss_sync   = ss_ff[SYNC_STAGES-1];
    assign mosi_sync = mosi_ff[SYNC_STAGES-1];
    assign ss_fall   = ss_prev & ~ss_sync;
    assign ss_rise   = ~ss_prev & ss_sync;
    assign sclk_fall = sclk_prev & ~sclk_ff[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev & sclk_ff[SYNC_STAGES-1];

    state_t             state, state_nxt;
    logic [15:0]        tx_shft, tx_shft_nxt;
    logic [15:0]        rx_shft, rx_shft_nxt;
    logic [15:0]        tx_buf, tx_buf_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic               seen_rise, seen_rise_nxt;
    logic [2:0]         last_chnl_nxt;
    logic               err_nxt, cmd_vld_nxt;
    logic               miso_q, miso_nxt;

    // Command decode of the received word.
    logic              frame_ok;
    logic [2:0]        chnl;
    logic [DATA_W-1:0] chnl_data;
    logic [3:0]        good_nib, bad_nib;

    assign chnl     = rx_shft[13:11];
    assign frame_ok = (bit_cnt == CNT_W'(FRAME_BITS)) &&
                      (rx_shft[15:14] == 2'b00) &&
                      (rx_shft[10:0] == 11'h000);

`ifdef A2D_SERF_CHNL_TAG_EN
    assign good_nib = {1'b1, chnl};
    assign bad_nib  = 4'hF;
`else
    assign good_nib = 4'h0;
    assign bad_nib  = 4'h0;
`endif

    // Channel value mux; unpopulated channels read as zero.
    always_comb begin
        chnl_data = '0;
        case (chnl)
            3'h0:    chnl_data = lft_ld_val;
            3'h4:    chnl_data = rght_ld_val;
            3'h5:    chnl_data = steer_val;
            3'h6:    chnl_data = batt_val;
            default: chnl_data = '0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_IDLE;
            tx_shft   <= '0;
            rx_shft   <= '0;
            tx_buf    <= '0;
            bit_cnt   <= '0;
            seen_rise <= 1'b0;
            last_chnl <= 3'h0;
            err       <= 1'b0;
            cmd_vld   <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_shft   <= tx_shft_nxt;
            rx_shft   <= rx_shft_nxt;
            tx_buf    <= tx_buf_nxt;
            bit_cnt   <= bit_cnt_nxt;
            seen_rise <= seen_rise_nxt;
            last_chnl <= last_chnl_nxt;
            err       <= err_nxt;
            cmd_vld   <= cmd_vld_nxt;
            miso_q    <= miso_nxt;
        end
    end

    assign spi.MISO = miso_q;

    // Next-state and datapath logic.
    always_comb begin
        state_nxt     = state;
        tx_shft_nxt   = tx_shft;
        rx_shft_nxt   = rx_shft;
        tx_buf_nxt    = tx_buf;
        bit_cnt_nxt   = bit_cnt;
        seen_rise_nxt = seen_rise;
        last_chnl_nxt = last_chnl;
        err_nxt       = err;
        cmd_vld_nxt   = 1'b0;

        case (state)
            // After reset bit_cnt doubles as a flush counter so the preset
            // synchronizer contents cannot be mistaken for an idle SS_n.
            WAIT_IDLE: begin
                if (bit_cnt != '1) begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
                if ((bit_cnt >= CNT_W'(SYNC_STAGES + 1)) && ss_sync) begin
                    state_nxt = IDLE;
                end
            end

            IDLE: begin
                if (ss_fall) begin
                    tx_shft_nxt   = tx_buf;
                    bit_cnt_nxt   = '0;
                    seen_rise_nxt = 1'b0;
                    state_nxt     = SHIFT;
                end
            end

            SHIFT: begin
                if (sclk_rise) begin
                    rx_shft_nxt   = {rx_shft[14:0], mosi_sync};
                    seen_rise_nxt = 1'b1;
                    if (bit_cnt != '1) begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end else if (sclk_fall && seen_rise) begin
                    // A fall before the first rise is front porch.
                    tx_shft_nxt = {tx_shft[14:0], 1'b0};
                end
                if (ss_rise) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                if (frame_ok) begin
                    last_chnl_nxt = chnl;
                    cmd_vld_nxt   = 1'b1;
                    tx_buf_nxt    = {good_nib, chnl_data};
                end else begin
                    err_nxt    = 1'b1;
                    tx_buf_nxt = {bad_nib, BAD_CMD_DATA};
                end
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase

        // Registered MISO tracks the MSB of the shifter as it will be next clk.
        miso_nxt = (state_nxt == SHIFT) ? tx_shft_nxt[15] : 1'b0;
    end

endmodule

// File: tb/tb_a2d_spi_serf.sv
// ----------------------------------------------------------------------------
// tb_a2d_spi_serf
// Randomized self-checking bench for a2d_spi_serf. A frame-level model keeps
// the pending response word, the sticky error, the last channel and the
// expected number of cmd_vld pulses.
// ----------------------------------------------------------------------------
module tb_a2d_spi_serf;

    localparam int HALF  = 6;   // SCLK half period in clk
    localparam int PORCH = 4;   // SS_n fall to first SCLK fall
    localparam int GAP   = 10;  // SS_n high time between frames

    logic        clk;
    logic        rst;
    logic [11:0] lft_ld_val, rght_ld_val, steer_val, batt_val;
    logic        cmd_vld;
    logic [2:0]  last_chnl;
    logic        err;

    a2d_spi_serf_if spi ();

    a2d_spi_serf dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (spi),
        .lft_ld_val  (lft_ld_val),
        .rght_ld_val (rght_ld_val),
        .steer_val   (steer_val),
        .batt_val    (batt_val),
        .cmd_vld     (cmd_vld),
        .last_chnl   (last_chnl),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // cmd_vld pulse counter
    int vld_cnt = 0;
    always @(negedge clk) if (cmd_vld === 1'b1) vld_cnt++;

    // Reference model state
    logic [15:0] exp_buf  = 16'h0000;
    logic [2:0]  exp_last = 3'h0;
    logic        exp_err  = 1'b0;
    int          exp_vld  = 0;

    // Values the inputs hold when the frame closes
    logic [11:0] fin_lft, fin_rght, fin_steer, fin_batt;

    function automatic logic [15:0] good_resp(input logic [2:0] ch, input logic [11:0] d);
`ifdef A2D_SERF_CHNL_TAG_EN
        return {1'b1, ch, d};
`else
        return {4'h0, d};
`endif
    endfunction

    function automatic logic [15:0] bad_resp();
`ifdef A2D_SERF_CHNL_TAG_EN
        return 16'hFFFF;
`else
        return 16'h0FFF;
`endif
    endfunction

    // Bits the monarch should see: pending word MSB first, zeros past 16.
    function automatic logic [31:0] exp_capture(input int n);
        logic [31:0] c = '0;
        logic [15:0] b = exp_buf;
        for (int i = 0; i < n; i++) begin
            c = {c[30:0], (i < 16) ? b[15] : 1'b0};
            b = {b[14:0], 1'b0};
        end
        return c;
    endfunction

    // Decode a finished frame the way the converter would.
    task automatic model_frame(input logic [15:0] cmd, input int n);
        logic [2:0]  ch;
        logic [11:0] d;
        ch = cmd[13:11];
        if (n == 16 && cmd[15:14] == 2'b00 && cmd[10:0] == 11'h0) begin
            case (ch)
                3'h0:    d = fin_lft;
                3'h4:    d = fin_rght;
                3'h5:    d = fin_steer;
                3'h6:    d = fin_batt;
                default: d = 12'h000;
            endcase
            exp_buf  = good_resp(ch, d);
            exp_last = ch;
            exp_vld++;
        end else begin
            exp_buf = bad_resp();
            exp_err = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_miso"}, 32'(spi.MISO), 32'd0);
        check({pfx, "_vld"},  32'(cmd_vld),  32'd0);
        check({pfx, "_last"}, 32'(last_chnl), 32'd0);
        check({pfx, "_err"},  32'(err),       32'd0);
    endtask

    // One SPI frame with n_rise SCLK cycles; rst pulsed after rise rst_at.
    task automatic do_frame(input logic [15:0] cmd, input int n_rise, input int rst_at,
                            output logic [31:0] cap);
        logic [15:0] c;
        c   = cmd;
        cap = '0;
        @(negedge clk);
        spi.SS_n = 1'b0;
        spi.MOSI = c[15];
        repeat (PORCH) @(negedge clk);
        for (int i = 0; i < n_rise; i++) begin
            spi.SCLK = 1'b0;
            spi.MOSI = (i < 16) ? c[15] : 1'($urandom);
            c = {c[14:0], 1'b0};
            // values in flight must not matter
            lft_ld_val  = 12'($urandom);
            rght_ld_val = 12'($urandom);
            steer_val   = 12'($urandom);
            batt_val    = 12'($urandom);
            repeat (HALF) @(negedge clk);
            cap = {cap[30:0], spi.MISO};
            spi.SCLK = 1'b1;
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                check_reset_outputs("midrst");
                rst = 1'b0;
            end
            repeat (HALF) @(negedge clk);
        end
        lft_ld_val  = fin_lft;
        rght_ld_val = fin_rght;
        steer_val   = fin_steer;
        batt_val    = fin_batt;
        spi.SS_n = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] cmd, input int n);
        logic [31:0] cap, expc;
        expc = exp_capture(n);
        do_frame(cmd, n, -1, cap);
        model_frame(cmd, n);
        check({tag, "_miso"}, cap, expc);
        check({tag, "_vld"},  32'(vld_cnt), 32'(exp_vld));
        check({tag, "_last"}, 32'(last_chnl), 32'(exp_last));
        check({tag, "_err"},  32'(err), 32'(exp_err));
    endtask

    task automatic set_vals(input logic [11:0] l, input logic [11:0] r,
                            input logic [11:0] s, input logic [11:0] b);
        fin_lft = l; fin_rght = r; fin_steer = s; fin_batt = b;
        lft_ld_val = l; rght_ld_val = r; steer_val = s; batt_val = b;
    endtask

    initial begin
        logic [31:0] cap;
        logic [15:0] cmd;
        int          n, r;

        rst = 1'b1;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        set_vals(12'h000, 12'h000, 12'h000, 12'h000);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Channel 0 twice: second frame returns lft value
        set_vals(12'hA5C, 12'h111, 12'h222, 12'h333);
        run_frame("t1a", 16'h0000, 16);
        run_frame("t1b", 16'h0000, 16);

        // Round robin, each command twice
        set_vals(12'h000, 12'h123, 12'h456, 12'hBEE);
        run_frame("t2a", 16'h2000, 16);
        run_frame("t2b", 16'h2000, 16);
        run_frame("t2c", 16'h2800, 16);
        run_frame("t2d", 16'h2800, 16);
        run_frame("t2e", 16'h3000, 16);
        run_frame("t2f", 16'h3000, 16);

        // Truncated frame, then a frame showing the bad-command response
        run_frame("t3a", 16'h2000, 9);
        run_frame("t3b", 16'h2800, 16);

        // Reserved bit set, then a good command
        run_frame("t4a", 16'h4000, 16);
        run_frame("t4b", 16'h2800, 16);
        run_frame("t4c", 16'h2800, 16);

        // Reset mid-frame with SS_n held low: frame discarded
        do_frame(16'h2000, 16, 6, cap);
        exp_buf = 16'h0000; exp_last = 3'h0; exp_err = 1'b0;
        check("t5_vld",  32'(vld_cnt), 32'(exp_vld));
        check("t5_err",  32'(err), 32'(exp_err));
        check("t5_last", 32'(last_chnl), 32'(exp_last));
        run_frame("t5a", 16'h3000, 16);
        set_vals(12'h000, 12'h000, 12'h000, 12'h7FF);
        run_frame("t5b", 16'h3000, 16);
        run_frame("t6",  16'h3000, 16);

        // Randomized frames
        for (int k = 0; k < 40; k++) begin
            set_vals(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
            r = int'($urandom_range(0, 9));
            n = 16;
            if (r < 6) begin
                cmd = {2'b00, 3'($urandom_range(0, 7)), 11'h000};
            end else if (r < 8) begin
                cmd = 16'($urandom);
            end else begin
                cmd = {2'b00, 3'($urandom_range(0, 7)), 11'h000};
                n   = int'($urandom_range(1, 20));
            end
            run_frame("rnd", cmd, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
